// File: rtl/mips_fetch_unit.sv
// Sequential instruction-fetch front end: word PC, pipelined IM request/response port,
// prefetch FIFO with registered head, and BEQ/J/JR redirect with in-flight response discard.
module mips_fetch_unit #(
    parameter int                ADDR_W          = 32,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REDIRECT_VALID,
    input  logic [1:0]        REDIRECT_TYPE,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    input  logic [25:0]       REDIRECT_IMM,
    input  logic [ADDR_W-1:0] REDIRECT_REG,
    output logic              IM_REQ_VALID,
    input  logic              IM_REQ_READY,
    output logic [ADDR_W-1:0] IM_REQ_ADDR,
    input  logic              IM_RSP_VALID,
    input  logic [31:0]       IM_RSP_DATA,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    output logic [31:0]       INSTR,
    output logic [ADDR_W-1:0] INSTR_PC,
    output logic [ADDR_W-1:0] INSTR_PCP1,
    output logic              PROTO_ERR
);

    localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);
    // Extra headroom: redirects can stack stale responses faster than a stalled memory returns them.
    localparam int DIS_W = OS_W + 3;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [OS_W-1:0]   r_outstanding;
    logic [DIS_W-1:0]  r_discard;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic              r_proto_err;
    logic [31:0]       r_mem_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [31:0]       r_head_data;
    logic [ADDR_W-1:0] r_head_pc;
    logic [ADDR_W-1:0] r_head_pcp1;

    logic              w_redirect;
    logic              w_reserved;
    logic              w_rsp_discard;
    logic              w_rsp_accept;
    logic              w_rsp_stray;
    logic              w_os_room;
    logic              w_credit;
    logic              w_req_valid;
    logic              w_issue;
    logic              w_instr_valid;
    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  w_count_after_pop;
    logic [PTR_W-1:0]  w_rd_next;
    logic [ADDR_W-1:0] w_pcp1;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_j_target;
    logic [ADDR_W-1:0] w_target;
    logic [31:0]       w_head_data_next;
    logic [ADDR_W-1:0] w_head_pc_next;

    assign w_redirect    = REDIRECT_VALID && (REDIRECT_TYPE != 2'b11);
    assign w_reserved    = REDIRECT_VALID && (REDIRECT_TYPE == 2'b11);
    assign w_rsp_discard = IM_RSP_VALID && (r_discard != '0);
    assign w_rsp_accept  = IM_RSP_VALID && (r_discard == '0) && (r_outstanding != '0);
    assign w_rsp_stray   = IM_RSP_VALID && (r_discard == '0) && (r_outstanding == '0);

    // Credit rule: every accepted request already owns a FIFO slot, so pushes never overflow.
    assign w_os_room     = r_outstanding < OS_W'(MAX_OUTSTANDING);
    assign w_credit      = (SUM_W'(r_count) + SUM_W'(r_outstanding)) < SUM_W'(FIFO_DEPTH);
    assign w_req_valid   = !RST && !REDIRECT_VALID && w_os_room && w_credit;
    assign w_issue       = w_req_valid && IM_REQ_READY;

    assign w_instr_valid = r_count != '0;
    assign w_pop         = w_instr_valid && INSTR_READY;
    assign w_push        = w_rsp_accept && !w_redirect;

    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_rd_next         = r_rd_ptr + PTR_W'(w_pop);

    assign w_pcp1 = REDIRECT_PC + ADDR_W'(1);

    generate
        if (ADDR_W > 16) begin : g_br_wide
            assign w_br_off = {{(ADDR_W-16){REDIRECT_IMM[15]}}, REDIRECT_IMM[15:0]};
        end else begin : g_br_narrow
            assign w_br_off = REDIRECT_IMM[ADDR_W-1:0];
        end
        if (ADDR_W > 26) begin : g_j_wide
            assign w_j_target = {w_pcp1[ADDR_W-1:26], REDIRECT_IMM};
        end else begin : g_j_narrow
            assign w_j_target = REDIRECT_IMM[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        w_target = REDIRECT_REG;
        case (REDIRECT_TYPE)
            2'b00:   w_target = w_pcp1 + w_br_off;
            2'b01:   w_target = w_j_target;
            default: w_target = REDIRECT_REG;
        endcase
    end

    // Next head: if the FIFO would be empty after this pop, the incoming response becomes head.
    always_comb begin
        w_head_data_next = r_mem_data[w_rd_next];
        w_head_pc_next   = r_mem_pc[w_rd_next];
        if (w_count_after_pop == '0) begin
            w_head_data_next = IM_RSP_DATA;
            w_head_pc_next   = r_rsp_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_proto_err <= r_proto_err | w_reserved | w_rsp_stray;
            if (w_redirect) begin
                r_fetch_pc    <= w_target;
                r_rsp_pc      <= w_target;
                r_outstanding <= '0;
                r_count       <= '0;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_discard     <= r_discard + DIS_W'(r_outstanding)
                                 - DIS_W'(w_rsp_discard || w_rsp_accept);
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                end
                r_outstanding <= r_outstanding + OS_W'(w_issue) - OS_W'(w_rsp_accept);
                if (w_rsp_discard) begin
                    r_discard <= r_discard - DIS_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_rsp_pc <= r_rsp_pc + ADDR_W'(1);
                end
                r_rd_ptr <= w_rd_next;
                r_count  <= w_count_after_pop + CNT_W'(w_push);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            r_mem_data[r_wr_ptr] <= IM_RSP_DATA;
            r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
        end
        r_head_data <= w_head_data_next;
        r_head_pc   <= w_head_pc_next;
        r_head_pcp1 <= w_head_pc_next + ADDR_W'(1);
    end

    assign IM_REQ_VALID = w_req_valid;
    assign IM_REQ_ADDR  = r_fetch_pc;
    assign INSTR_VALID  = w_instr_valid;
    assign INSTR        = r_head_data;
    assign INSTR_PC     = r_head_pc;
    assign INSTR_PCP1   = r_head_pcp1;
    assign PROTO_ERR    = r_proto_err;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: in-order memory model plus a program-order stream model
// that predicts every fetched PC, word and redirect target.
module tb_mips_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h10;

    logic        CLK;
    logic        RST;
    logic        REDIRECT_VALID;
    logic [1:0]  REDIRECT_TYPE;
    logic [31:0] REDIRECT_PC;
    logic [25:0] REDIRECT_IMM;
    logic [31:0] REDIRECT_REG;
    logic        IM_REQ_VALID;
    logic        IM_REQ_READY;
    logic [31:0] IM_REQ_ADDR;
    logic        IM_RSP_VALID;
    logic [31:0] IM_RSP_DATA;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic [31:0] INSTR_PCP1;
    logic        PROTO_ERR;

    mips_fetch_unit #(
        .ADDR_W(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_TYPE(REDIRECT_TYPE),
        .REDIRECT_PC(REDIRECT_PC), .REDIRECT_IMM(REDIRECT_IMM), .REDIRECT_REG(REDIRECT_REG),
        .IM_REQ_VALID(IM_REQ_VALID), .IM_REQ_READY(IM_REQ_READY), .IM_REQ_ADDR(IM_REQ_ADDR),
        .IM_RSP_VALID(IM_RSP_VALID), .IM_RSP_DATA(IM_RSP_DATA),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
        .INSTR_PC(INSTR_PC), .INSTR_PCP1(INSTR_PCP1), .PROTO_ERR(PROTO_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] mem_q[$];
    bit          rsp_en;
    bit          stray;
    bit          last_pop;
    logic [31:0] last_pop_pc;
    bit          last_req;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] target(input logic [1:0] t, input logic [31:0] pc,
                                           input logic [25:0] imm, input logic [31:0] r);
        logic [31:0] nxt;
        nxt = pc + 32'd1;
        case (t)
            2'b00:   return nxt + {{16{imm[15]}}, imm[15:0]};
            2'b01:   return {nxt[31:26], imm};
            default: return r;
        endcase
    endfunction

    // One clock: drive memory response, observe handshakes, advance the models, end at negedge.
    task automatic cycle();
        bit          stray_now;
        bit          rst_now;
        bit          req_fire;
        bit          pop_fire;
        bit          rsp_fire;
        logic [31:0] req_addr;
        stray_now = stray;
        if (stray) begin
            IM_RSP_VALID = 1'b1;
            IM_RSP_DATA  = 32'hDEAD_BEEF;
        end else if (rsp_en && mem_q.size() > 0) begin
            IM_RSP_VALID = 1'b1;
            IM_RSP_DATA  = hash(mem_q[0]);
        end else begin
            IM_RSP_VALID = 1'b0;
            IM_RSP_DATA  = '0;
        end
        #1;
        rst_now  = RST;
        req_fire = IM_REQ_VALID && IM_REQ_READY;
        req_addr = IM_REQ_ADDR;
        pop_fire = INSTR_VALID && INSTR_READY;
        rsp_fire = IM_RSP_VALID;
        last_pop = pop_fire;
        last_req = req_fire;
        last_req_addr = req_addr;
        if (pop_fire) begin
            last_pop_pc = INSTR_PC;
            pops++;
            checks++;
            if (INSTR_PC !== exp_pc)
                $display("FAIL stream_pc got %h want %h", INSTR_PC, exp_pc);
            checks++;
            if (INSTR !== hash(exp_pc))
                $display("FAIL stream_instr got %h want %h", INSTR, hash(exp_pc));
            checks++;
            if (INSTR_PCP1 !== exp_pc + 32'd1)
                $display("FAIL stream_pcp1 got %h want %h", INSTR_PCP1, exp_pc + 32'd1);
            if (INSTR_PC !== exp_pc || INSTR !== hash(exp_pc) || INSTR_PCP1 !== exp_pc + 32'd1)
                errors++;
            exp_pc = (INSTR_PC !== exp_pc) ? INSTR_PC + 32'd1 : exp_pc + 32'd1;
        end
        if (req_fire) begin
            checks++;
            if (req_addr !== exp_req) begin
                errors++;
                $display("FAIL req_addr got %h want %h", req_addr, exp_req);
            end
            exp_req = req_addr + 32'd1;
        end
        if (rsp_fire && !stray_now) void'(mem_q.pop_front());
        if (REDIRECT_VALID && REDIRECT_TYPE != 2'b11) begin
            exp_pc  = target(REDIRECT_TYPE, REDIRECT_PC, REDIRECT_IMM, REDIRECT_REG);
            exp_req = exp_pc;
        end
        @(posedge CLK);
        if (rst_now) begin
            mem_q.delete();
            exp_pc  = RST_PC;
            exp_req = RST_PC;
        end else if (req_fire) begin
            mem_q.push_back(req_addr);
        end
        @(negedge CLK);
    endtask

    task automatic run_until_pop(input string name, input logic [31:0] want_pc);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_pop && n < 50);
        checks++;
        if (!last_pop || last_pop_pc !== want_pc) begin
            errors++;
            $display("FAIL %s popped=%0b pc %h want %h", name, last_pop, last_pop_pc, want_pc);
        end
        $display("%s first pc %h", name, last_pop_pc);
    endtask

    task automatic test_reset();
        RST = 1'b1; INSTR_READY = 1'b0; IM_REQ_READY = 1'b1; rsp_en = 1'b1;
        repeat (3) cycle();
        checks++;
        if (INSTR_VALID !== 1'b0 || IM_REQ_VALID !== 1'b0 || PROTO_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state valid=%b req=%b perr=%b want 0 0 0",
                     INSTR_VALID, IM_REQ_VALID, PROTO_ERR);
        end
        RST = 1'b0;
        $display("reset: outputs idle");
    endtask

    task automatic test_sequential();
        int p0;
        INSTR_READY = 1'b1;
        cycle();
        checks++;
        if (!last_req || last_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req fired=%0b addr %h want %h", last_req, last_req_addr, RST_PC);
        end
        run_until_pop("sequential", RST_PC);
        p0 = pops;
        repeat (20) cycle();
        checks++;
        if (pops - p0 != 20) begin
            errors++;
            $display("FAIL throughput got %0d want 20", pops - p0);
        end
        $display("sequential: %0d pops in 20 cycles", pops - p0);
    endtask

    task automatic test_stall_fill();
        int p0;
        INSTR_READY = 1'b0;
        repeat (10) cycle();
        checks++;
        if (IM_REQ_VALID !== 1'b0 || INSTR_VALID !== 1'b1 || mem_q.size() != 0) begin
            errors++;
            $display("FAIL stall_full req=%b valid=%b inflight=%0d want 0 1 0",
                     IM_REQ_VALID, INSTR_VALID, mem_q.size());
        end
        INSTR_READY = 1'b1;
        p0 = pops;
        repeat (8) cycle();
        checks++;
        if (pops - p0 != 8) begin
            errors++;
            $display("FAIL stall_drain got %0d want 8", pops - p0);
        end
        $display("stall: drained %0d in order", pops - p0);
    endtask

    task automatic test_branch_latency();
        IM_REQ_READY = 1'b0; rsp_en = 1'b1;
        repeat (6) cycle();
        IM_REQ_READY = 1'b1; rsp_en = 1'b0;
        repeat (4) cycle();
        checks++;
        if (mem_q.size() != 2 || IM_REQ_VALID !== 1'b0) begin
            errors++;
            $display("FAIL outstanding_cap inflight=%0d req=%b want 2 0", mem_q.size(), IM_REQ_VALID);
        end
        INSTR_READY = 1'b0; rsp_en = 1'b1;
        REDIRECT_VALID = 1'b1; REDIRECT_TYPE = 2'b00;
        REDIRECT_PC = 32'h20; REDIRECT_IMM = 26'h000FFFE;
        cycle();
        REDIRECT_VALID = 1'b0;
        checks++;
        if (INSTR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL branch_n got valid %b want 0", INSTR_VALID);
        end
        cycle();
        checks++;
        if (INSTR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL branch_n1 got valid %b want 0", INSTR_VALID);
        end
        cycle();
        checks++;
        if (INSTR_VALID !== 1'b1 || INSTR_PC !== 32'h1F || INSTR !== hash(32'h1F)) begin
            errors++;
            $display("FAIL branch_n2 valid=%b pc %h instr %h want 1 0000001f %h",
                     INSTR_VALID, INSTR_PC, INSTR, hash(32'h1F));
        end
        $display("branch: head pc %h after redirect", INSTR_PC);
        INSTR_READY = 1'b1;
        repeat (10) cycle();
    endtask

    task automatic test_jump_jr();
        REDIRECT_VALID = 1'b1; REDIRECT_TYPE = 2'b01;
        REDIRECT_PC = 32'h0400_0000; REDIRECT_IMM = 26'h0000040;
        cycle();
        REDIRECT_VALID = 1'b0;
        run_until_pop("jump", 32'h0400_0040);
        repeat (5) cycle();
        REDIRECT_VALID = 1'b1; REDIRECT_TYPE = 2'b10; REDIRECT_REG = 32'h55;
        cycle();
        REDIRECT_VALID = 1'b0;
        run_until_pop("jr", 32'h55);
        repeat (5) cycle();
    endtask

    task automatic test_random();
        int p0;
        p0 = pops;
        for (int i = 0; i < 1500; i++) begin
            IM_REQ_READY = ($urandom % 4) != 0;
            rsp_en       = ($urandom % 4) != 0;
            INSTR_READY  = ($urandom % 3) != 0;
            REDIRECT_VALID = ($urandom % 25) == 0;
            REDIRECT_TYPE  = 2'($urandom_range(0, 2));
            REDIRECT_PC    = $urandom;
            REDIRECT_IMM   = 26'($urandom);
            REDIRECT_REG   = $urandom;
            cycle();
        end
        REDIRECT_VALID = 1'b0; IM_REQ_READY = 1'b1; rsp_en = 1'b1; INSTR_READY = 1'b1;
        repeat (10) cycle();
        checks++;
        if (pops - p0 < 200) begin
            errors++;
            $display("FAIL random_progress got %0d pops want >= 200", pops - p0);
        end
        $display("random: %0d pops checked", pops - p0);
    endtask

    task automatic test_reset_mid();
        INSTR_READY = 1'b0;
        repeat (3) cycle();
        rsp_en = 1'b0;
        repeat (3) cycle();
        checks++;
        if (INSTR_VALID !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_fill got valid %b want 1", INSTR_VALID);
        end
        RST = 1'b1;
        cycle();
        checks++;
        if (INSTR_VALID !== 1'b0 || IM_REQ_VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset valid=%b req=%b want 0 0", INSTR_VALID, IM_REQ_VALID);
        end
        RST = 1'b0; rsp_en = 1'b1;
        cycle();
        checks++;
        if (!last_req || last_req_addr !== RST_PC) begin
            errors++;
            $display("FAIL post_reset_req fired=%0b addr %h want %h", last_req, last_req_addr, RST_PC);
        end
        INSTR_READY = 1'b1;
        run_until_pop("reset_mid", RST_PC);
    endtask

    task automatic test_proto_err();
        int p0;
        checks++;
        if (PROTO_ERR !== 1'b0) begin
            errors++;
            $display("FAIL perr_clean got %b want 0", PROTO_ERR);
        end
        IM_REQ_READY = 1'b0;
        repeat (8) cycle();
        stray = 1'b1;
        cycle();
        stray = 1'b0;
        checks++;
        if (PROTO_ERR !== 1'b1 || INSTR_VALID !== 1'b0) begin
            errors++;
            $display("FAIL perr_stray perr=%b valid=%b want 1 0", PROTO_ERR, INSTR_VALID);
        end
        IM_REQ_READY = 1'b1;
        repeat (10) cycle();
        checks++;
        if (PROTO_ERR !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky got %b want 1", PROTO_ERR);
        end
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        checks++;
        if (PROTO_ERR !== 1'b0) begin
            errors++;
            $display("FAIL perr_reset got %b want 0", PROTO_ERR);
        end
        repeat (5) cycle();
        REDIRECT_VALID = 1'b1; REDIRECT_TYPE = 2'b11;
        REDIRECT_PC = 32'h1234; REDIRECT_REG = 32'h999;
        cycle();
        REDIRECT_VALID = 1'b0;
        p0 = pops;
        repeat (10) cycle();
        checks++;
        if (PROTO_ERR !== 1'b1 || pops - p0 < 8) begin
            errors++;
            $display("FAIL perr_reserved perr=%b pops=%0d want 1 >=8", PROTO_ERR, pops - p0);
        end
        $display("proto_err: stray and reserved flagged");
    endtask

    initial begin
        RST = 1'b1; REDIRECT_VALID = 1'b0; REDIRECT_TYPE = 2'b00; REDIRECT_PC = '0;
        REDIRECT_IMM = '0; REDIRECT_REG = '0; IM_REQ_READY = 1'b1; IM_RSP_VALID = 1'b0;
        IM_RSP_DATA = '0; INSTR_READY = 1'b0;
        rsp_en = 1'b1; stray = 1'b0; exp_pc = RST_PC; exp_req = RST_PC;
        last_pop = 1'b0; last_pop_pc = '0; last_req = 1'b0; last_req_addr = '0;
        @(negedge CLK);
        test_reset();
        test_sequential();
        test_stall_fill();
        test_branch_latency();
        test_jump_jr();
        test_random();
        test_reset_mid();
        test_proto_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
